q2_sequencer: RTL and testbench
===============================

// Module: q2_sequencer
// PURPOSE
//  Fetch/execute sequencer for the Q2 bit-slice datapath. It generates every slice strobe:
//   wra/rda, incp_clk/nwrp/rdp, wrx/rdx/xin_*, wrs and dep.
//  It runs a memory read/write handshake and a front-panel run/step/deposit control.
//  One instance sits beside the slice array; its outputs fan out to all slices.
// PARAMETERS
//  OPW      3   opcode width, latched from mem_op during fetch
//  TIMEOUT  15  cycles to wait for mem_ready before flagging bus_err; 0 = wait forever
// PORTS
//  clk        in   1    system clock
//  nrst       in   1    asynchronous active-low reset
//  run        in   1    level: 1 = free-run, 0 = halt at next instruction boundary
//  step       in   1    1-cycle pulse: execute one instruction while halted
//  panel_dep  in   1    1-cycle pulse: deposit switch data while halted
//  mem_op     in   OPW  opcode field of the word on dbus; valid when mem_ready=1
//  mem_ready  in   1    memory acknowledges the current mem_rd/mem_wr
//  xzero      in   1    wired-AND of slice nxout: X==0
//  mem_rd     out  1    memory read request, address = abus
//  mem_wr     out  1    memory write request, address = abus, data = dbus
//  rdp rdx rda out 1    drive P, X onto abus; drive A onto dbus
//  wrx wra wrs out 1    1-cycle register write pulses to X, A, S
//  incp_clk   out  1    1-cycle P increment clock pulse
//  nwrp       out  1    active-low: load P from X
//  nsw        out  1    active-low: switch/panel mode
//  dep        out  1    drive panel data onto dbus
//  xin_zero xin_p xin_shift xin_dbus  out 1  X source select, one-hot or all 0
//  halted     out  1    1 in HALT state
//  bus_err    out  1    sticky memory timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset, async: state=HALT. All strobes, selects, mem_rd, mem_wr, dep, bus_err = 0.
//   nwrp=1, nsw=0, halted=1. The slice P bits clear through nrst.
//  Outputs are registered. The state sets the strobes; no output is a combinational function of inputs.
//  States and transitions:
//   HALT: nsw=0.
//    panel_dep -> DEP. Else run=1 or step -> FETCH, latch one_shot=step&!run.
//   DEP: dep=1, then DEP_W with mem_wr=1 and dep=1 held until mem_ready -> HALT.
//   FETCH: nsw=1, rdp=1, mem_rd=1, xin_dbus=1. Hold until mem_ready.
//    On mem_ready: wrx=1 for that cycle and latch IR<=mem_op -> INCP.
//   INCP: incp_clk=1 for 1 cycle -> EXEC.
//   EXEC, by IR:
//    0 LDA: rdx, mem_rd until ready; wra on ready.
//    1 STA: rdx, rda, mem_wr until ready.
//    2 JMP: nwrp=0 for 1 cycle.
//    3 JZ:  nwrp=0 for 1 cycle only if xzero=1, else no-op.
//    4 SHL: xin_shift=1 with wrx pulse, then wrs pulse, 2 cycles.
//    5 CLX: xin_zero=1 with wrx pulse.
//    6 LXP: xin_p=1 with wrx pulse.
//    7 HLT: -> HALT.
//   Then: run=1 and !one_shot -> FETCH, else -> HALT.
//  Latency: no-wait JMP instruction = 4 cycles (FETCH, INCP, EXEC, boundary). Each wait cycle adds 1.
//  mem_rd and mem_wr are never asserted together. Request stays high until the cycle mem_ready=1, then drops.
//  Timeout: TIMEOUT cycles without mem_ready -> bus_err=1, request dropped -> HALT.
//  run falling mid-instruction: the instruction completes, then HALT. Never abandoned.
//  step or panel_dep outside HALT are ignored. panel_dep and step together in HALT: deposit wins.
//  At most one of wrx/wra/wrs/incp_clk/!nwrp is active per cycle.
//   Each strobe is preceded by at least 1 cycle of stable selects. FETCH selects are asserted from state entry.
// TESTING
//  Reset mid-STA with mem_wr=1 -> same cycle: mem_wr=0, nwrp=1, halted=1, nsw=0.
//  run=1, memory returns JMP with 0-wait -> rdp/mem_rd, wrx, incp_clk, nwrp=0, one per cycle; FETCH again on cycle 5.
//  LDA, mem_ready delayed 3 cycles -> rdx and mem_rd held 3 cycles; wra pulses exactly once on the ready cycle.
//  JZ with xzero=0 and then with xzero=1 -> nwrp stays 1, then nwrp=0 for exactly 1 cycle.
//  Halted, step pulse -> exactly one instruction, back to HALT. panel_dep+step together -> DEP only, dep=1 until ready.
//  TIMEOUT=15, mem_ready never asserted -> bus_err=1 after 15 cycles, mem_rd=0, halted=1, bus_err sticky.

Source files
------------

// File: rtl/q2_sequencer.sv
// q2_sequencer: fetch/execute sequencer for the Q2 bit-slice datapath.
// Generates every slice strobe, the memory handshake and front-panel run/step/deposit control.
module q2_sequencer #(
   parameter int OPW     = 3,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic           run,
   input  logic           step,
   input  logic           panel_dep,
   input  logic [OPW-1:0] mem_op,
   input  logic           mem_ready,
   input  logic           xzero,
   output logic           mem_rd,
   output logic           mem_wr,
   output logic           rdp,
   output logic           rdx,
   output logic           rda,
   output logic           wrx,
   output logic           wra,
   output logic           wrs,
   output logic           incp_clk,
   output logic           nwrp,
   output logic           nsw,
   output logic           dep,
   output logic           xin_zero,
   output logic           xin_p,
   output logic           xin_shift,
   output logic           xin_dbus,
   output logic           halted,
   output logic           bus_err
);

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [OPW-1:0] OP_LDA = OPW'(0);
   localparam logic [OPW-1:0] OP_STA = OPW'(1);
   localparam logic [OPW-1:0] OP_JMP = OPW'(2);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(3);
   localparam logic [OPW-1:0] OP_SHL = OPW'(4);
   localparam logic [OPW-1:0] OP_CLX = OPW'(5);
   localparam logic [OPW-1:0] OP_LXP = OPW'(6);
   localparam logic [OPW-1:0] OP_HLT = OPW'(7);

   typedef enum logic [2:0] {
      S_HALT,
      S_DEP,
      S_DEP_W,
      S_FETCH,
      S_LOAD,
      S_INCP,
      S_EXEC,
      S_EXEC2
   } state_t;

   state_t         state_q, state_d, boundary;
   logic [OPW-1:0] ir_q, ir_d;
   logic           one_shot_q, one_shot_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           err_d;
   logic           req;
   logic           timeout;
   logic           exec_d;
   logic           xsel_d;

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      one_shot_d = one_shot_q;
      wait_d     = '0;
      timeout    = 1'b0;
      boundary   = (run && !one_shot_q) ? S_FETCH : S_HALT;
      req        = (state_q == S_DEP_W) || (state_q == S_FETCH) ||
                   ((state_q == S_EXEC) && ((ir_q == OP_LDA) || (ir_q == OP_STA)));
      if (req && !mem_ready) begin
         wait_d  = wait_q + 1'b1;
         timeout = (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == 32'(TIMEOUT));
      end
      err_d = bus_err | timeout;

      case (state_q)
         S_HALT: begin
            if (panel_dep) begin
               state_d = S_DEP;
            end else if (run || step) begin
               state_d    = S_FETCH;
               one_shot_d = step & ~run;
            end
         end
         S_DEP:   state_d = S_DEP_W;
         S_DEP_W: if (mem_ready) state_d = S_HALT;
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_LOAD;
               ir_d    = mem_op;
            end
         end
         S_LOAD:  state_d = S_INCP;
         S_INCP:  state_d = S_EXEC;
         S_EXEC: begin
            case (ir_q)
               OP_LDA:  if (mem_ready) state_d = S_EXEC2;
               OP_STA:  if (mem_ready) state_d = boundary;
               OP_SHL:  state_d = S_EXEC2;
               OP_HLT:  state_d = S_HALT;
               default: state_d = boundary;
            endcase
         end
         S_EXEC2: state_d = boundary;
         default: state_d = S_HALT;
      endcase

      // a timed-out request abandons whatever access was in flight
      if (timeout) state_d = S_HALT;
   end

   assign exec_d = (state_d == S_EXEC);
   assign xsel_d = (state_d == S_INCP) || (state_d == S_EXEC);

   // Outputs decode the next state so they are registered and valid from state entry;
   // X source selects rise in INCP, one cycle ahead of the EXEC wrx pulse.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_HALT;
         ir_q       <= '0;
         one_shot_q <= 1'b0;
         wait_q     <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         rdp        <= 1'b0;
         rdx        <= 1'b0;
         rda        <= 1'b0;
         wrx        <= 1'b0;
         wra        <= 1'b0;
         wrs        <= 1'b0;
         incp_clk   <= 1'b0;
         nwrp       <= 1'b1;
         nsw        <= 1'b0;
         dep        <= 1'b0;
         xin_zero   <= 1'b0;
         xin_p      <= 1'b0;
         xin_shift  <= 1'b0;
         xin_dbus   <= 1'b0;
         halted     <= 1'b1;
         bus_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         one_shot_q <= one_shot_d;
         wait_q     <= wait_d;
         mem_rd     <= (state_d == S_FETCH) || (exec_d && (ir_d == OP_LDA));
         mem_wr     <= (state_d == S_DEP_W) || (exec_d && (ir_d == OP_STA));
         rdp        <= (state_d == S_FETCH) || (state_d == S_LOAD);
         rdx        <= exec_d && ((ir_d == OP_LDA) || (ir_d == OP_STA));
         rda        <= exec_d && (ir_d == OP_STA);
         wrx        <= (state_d == S_LOAD) ||
                       (exec_d && ((ir_d == OP_SHL) || (ir_d == OP_CLX) || (ir_d == OP_LXP)));
         wra        <= (state_d == S_EXEC2) && (ir_d == OP_LDA);
         wrs        <= (state_d == S_EXEC2) && (ir_d == OP_SHL);
         incp_clk   <= (state_d == S_INCP);
         nwrp       <= !(exec_d && ((ir_d == OP_JMP) || ((ir_d == OP_JZ) && xzero)));
         nsw        <= !((state_d == S_HALT) || (state_d == S_DEP) || (state_d == S_DEP_W));
         dep        <= (state_d == S_DEP) || (state_d == S_DEP_W);
         xin_zero   <= xsel_d && (ir_d == OP_CLX);
         xin_p      <= xsel_d && (ir_d == OP_LXP);
         xin_shift  <= xsel_d && (ir_d == OP_SHL);
         xin_dbus   <= (state_d == S_FETCH) || (state_d == S_LOAD);
         halted     <= (state_d == S_HALT);
         bus_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_q2_sequencer.sv
// tb_q2_sequencer: checks q2_sequencer cycle by cycle against an expected strobe schedule
// built per instruction from the fetch/execute rules, with randomized programs and waits.
module tb_q2_sequencer;
   localparam int OPW     = 3;
   localparam int TIMEOUT = 15;

   // one bit per observed output, nwrp taken as active-high P-load
   localparam logic [17:0] RD     = 18'h00001, WR    = 18'h00002, RDP    = 18'h00004,
                           RDX    = 18'h00008, RDA   = 18'h00010, WRX    = 18'h00020,
                           WRA    = 18'h00040, WRS   = 18'h00080, INCP   = 18'h00100,
                           PLOAD  = 18'h00200, SW    = 18'h00400, DEP    = 18'h00800,
                           XZERO  = 18'h01000, XP    = 18'h02000, XSHIFT = 18'h04000,
                           XDBUS  = 18'h08000, HALTED = 18'h10000, BERR  = 18'h20000;

   logic           clk;
   logic           nrst, run, step, panel_dep, mem_ready, xzero;
   logic [OPW-1:0] mem_op;
   logic           mem_rd, mem_wr, rdp, rdx, rda, wrx, wra, wrs, incp_clk, nwrp, nsw, dep;
   logic           xin_zero, xin_p, xin_shift, xin_dbus, halted, bus_err;

   typedef struct {
      logic [17:0]    exp;
      logic           run;
      logic           step;
      logic           pdep;
      logic           rdy;
      logic           xz;
      logic [OPW-1:0] op;
   } cyc_t;

   cyc_t        sched[$];
   logic        cur_run, cur_xz, sticky;
   int unsigned n_checks, n_errors;

   q2_sequencer #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .nrst(nrst), .run(run), .step(step), .panel_dep(panel_dep),
      .mem_op(mem_op), .mem_ready(mem_ready), .xzero(xzero),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .rdp(rdp), .rdx(rdx), .rda(rda),
      .wrx(wrx), .wra(wra), .wrs(wrs), .incp_clk(incp_clk), .nwrp(nwrp),
      .nsw(nsw), .dep(dep), .xin_zero(xin_zero), .xin_p(xin_p),
      .xin_shift(xin_shift), .xin_dbus(xin_dbus), .halted(halted), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] obs();
      return {bus_err, halted, xin_dbus, xin_shift, xin_p, xin_zero, dep, nsw, ~nwrp,
              incp_clk, wrs, wra, wrx, rda, rdx, rdp, mem_wr, mem_rd};
   endfunction

   function automatic logic noise();
      return ($urandom_range(0, 5) == 0);
   endfunction

   function automatic logic [17:0] xsel(input logic [2:0] op);
      case (op)
         3'd4:    return XSHIFT;
         3'd5:    return XZERO;
         3'd6:    return XP;
         default: return 18'h0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [17:0] e, input logic rdy, input logic [OPW-1:0] op,
                       input logic stp, input logic pd);
      cyc_t c;
      c.exp  = e | (sticky ? BERR : 18'h0);
      c.run  = cur_run;
      c.step = stp;
      c.pdep = pd;
      c.rdy  = rdy;
      c.xz   = cur_xz;
      c.op   = rdy ? op : OPW'($urandom);
      sched.push_back(c);
   endtask

   task automatic halt_cyc(input logic stp, input logic pd);
      push(HALTED, 1'b0, '0, stp, pd);
   endtask

   // One instruction: fetch (wf wait cycles), latch, P increment, execute (we wait cycles).
   // stop: run is low from mid-instruction on, so HALT follows it.
   task automatic gen_insn(input logic [2:0] op, input int unsigned wf, input int unsigned we,
                           input logic xz, input logic stop);
      cur_xz = xz;
      for (int unsigned i = 0; i <= wf; i++) push(SW|RD|RDP|XDBUS, i == wf, op, noise(), noise());
      push(SW|RDP|XDBUS|WRX, 1'b0, '0, noise(), noise());
      if (stop) cur_run = 1'b0;
      push(SW|INCP|xsel(op), 1'b0, '0, noise(), noise());
      case (op)
         3'd0: begin
            for (int unsigned i = 0; i <= we; i++)
               push(SW|RDX|RD, i == we, OPW'($urandom), noise(), noise());
            push(SW|WRA, 1'b0, '0, noise(), noise());
         end
         3'd1: begin
            for (int unsigned i = 0; i <= we; i++)
               push(SW|RDX|RDA|WR, i == we, OPW'($urandom), noise(), noise());
         end
         3'd2: push(SW|PLOAD, 1'b0, '0, noise(), noise());
         3'd3: push(SW | (xz ? PLOAD : 18'h0), 1'b0, '0, noise(), noise());
         3'd4: begin
            push(SW|XSHIFT|WRX, 1'b0, '0, noise(), noise());
            push(SW|WRS, 1'b0, '0, noise(), noise());
         end
         3'd5: push(SW|XZERO|WRX, 1'b0, '0, noise(), noise());
         3'd6: push(SW|XP|WRX, 1'b0, '0, noise(), noise());
         default: push(SW, 1'b0, '0, noise(), noise());
      endcase
   endtask

   task automatic play(input string tag);
      int unsigned idx = 0;
      cyc_t c;
      while (sched.size() > 0) begin
         c = sched.pop_front();
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, idx), obs(), c.exp);
         run       = c.run;
         step      = c.step;
         panel_dep = c.pdep;
         mem_ready = c.rdy;
         mem_op    = c.op;
         xzero     = c.xz;
         idx++;
      end
   endtask

   initial begin
      nrst = 1'b1; run = 1'b0; step = 1'b0; panel_dep = 1'b0;
      mem_ready = 1'b0; mem_op = '0; xzero = 1'b0;
      cur_run = 1'b0; cur_xz = 1'b0; sticky = 1'b0;
      n_checks = 0; n_errors = 0;

      // asynchronous reset
      #1 nrst = 1'b0;
      #1 check("reset", obs(), HALTED);
      @(negedge clk);
      nrst = 1'b1;

      // free-run JMP, zero-wait: FETCH again on cycle 5; run falls during the second JMP
      cur_run = 1'b1;
      halt_cyc(1'b0, 1'b0);
      gen_insn(3'd2, 0, 0, 1'b0, 1'b0);
      gen_insn(3'd2, 0, 0, 1'b0, 1'b1);
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b0, 1'b0);
      play("jmp");

      // stepped LDA whose read is acknowledged on the third request cycle
      halt_cyc(1'b1, 1'b0);
      gen_insn(3'd0, 0, 2, 1'b0, 1'b1);
      halt_cyc(1'b0, 1'b0);
      play("lda_wait");

      // JZ not taken, then taken
      halt_cyc(1'b1, 1'b0);
      gen_insn(3'd3, 1, 0, 1'b0, 1'b1);
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b1, 1'b0);
      gen_insn(3'd3, 0, 0, 1'b1, 1'b1);
      halt_cyc(1'b0, 1'b0);
      play("jz");

      // every opcode single-stepped with random waits
      for (int unsigned op = 0; op < 8; op++) begin
         halt_cyc(1'b1, 1'b0);
         gen_insn(3'(op), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b1);
         halt_cyc(1'b0, 1'b0);
         halt_cyc(1'b0, 1'b0);
      end
      play("step_all");

      // deposit and step together: deposit only
      halt_cyc(1'b1, 1'b1);
      push(DEP, 1'b0, '0, noise(), noise());
      for (int unsigned i = 0; i <= 2; i++) push(DEP|WR, i == 2, '0, noise(), noise());
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b0, 1'b0);
      play("deposit");

      // random free-running programs
      for (int unsigned r = 0; r < 4; r++) begin
         cur_run = 1'b1;
         halt_cyc(1'b0, 1'b0);
         for (int unsigned k = 0; k < 8; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            gen_insn(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), k == 7);
            if (op == 3'd7 || k == 7) halt_cyc(1'b0, 1'b0);
         end
         halt_cyc(1'b0, 1'b0);
         play($sformatf("rand%0d", r));
      end

      // reset while STA holds mem_wr
      halt_cyc(1'b1, 1'b0);
      push(SW|RD|RDP|XDBUS, 1'b1, 3'd1, 1'b0, 1'b0);
      push(SW|RDP|XDBUS|WRX, 1'b0, '0, 1'b0, 1'b0);
      push(SW|INCP, 1'b0, '0, 1'b0, 1'b0);
      push(SW|RDX|RDA|WR, 1'b0, '0, 1'b0, 1'b0);
      play("sta_pre");
      #2 nrst = 1'b0;
      #1 check("reset_mid_sta", obs(), HALTED);
      @(negedge clk);
      check("reset_hold", obs(), HALTED);
      nrst = 1'b1;

      // fetch timeout, sticky bus_err, then an LDA timeout in EXEC
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b1, 1'b0);
      for (int unsigned i = 0; i < TIMEOUT; i++) push(SW|RD|RDP|XDBUS, 1'b0, '0, 1'b0, 1'b0);
      sticky = 1'b1;
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b1, 1'b0);
      gen_insn(3'd5, 1, 0, 1'b0, 1'b1);
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b1, 1'b0);
      push(SW|RD|RDP|XDBUS, 1'b1, 3'd0, 1'b0, 1'b0);
      push(SW|RDP|XDBUS|WRX, 1'b0, '0, 1'b0, 1'b0);
      push(SW|INCP, 1'b0, '0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < TIMEOUT; i++) push(SW|RDX|RD, 1'b0, '0, 1'b0, 1'b0);
      halt_cyc(1'b0, 1'b0);
      halt_cyc(1'b0, 1'b0);
      play("timeout");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
